// File: rtl/ovl_win_unchange_mc.sv
// Multi-channel window checker: each channel watches its test_expr slice between
// start_event and end_event, flagging unchanged/changed violations and window timeouts.
module ovl_win_unchange_mc #(
  parameter int unsigned NCH        = 2,
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned MODE       = 0,
  parameter int unsigned MAX_WINDOW = 0,
  parameter int unsigned CNT_W      = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [NCH-1:0]       start_event,
  input  logic [NCH-1:0]       end_event,
  input  logic [NCH*WIDTH-1:0] test_expr,
  output logic [NCH-1:0]       window_open,
  output logic [NCH-1:0]       fire,
  output logic [NCH-1:0]       fire_timeout,
  output logic [CNT_W-1:0]     err_count
);

  localparam int unsigned CW = (MAX_WINDOW > 0) ? $clog2(MAX_WINDOW + 1) : 1;

  typedef enum logic {StIdle, StWindow} state_e;

  logic [NCH-1:0] fire_d;
  logic [NCH-1:0] timeout_d;

  for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
    state_e           state_q;
    logic [WIDTH-1:0] slice;
    logic [WIDTH-1:0] ref_q;
    logic             changed_q;
    logic [CW-1:0]    cnt_q;
    logic             fire_q;
    logic             timeout_q;
    logic             mism;
    logic             in_win;
    logic             val_viol;
    logic             to_viol;

    assign slice  = test_expr[ch*WIDTH +: WIDTH];
    // Case inequality so an X/Z bit counts as a mismatch.
    assign mism   = (slice !== ref_q);
    assign in_win = (state_q == StWindow);

    assign val_viol = in_win && ((MODE == 0) ? mism
                                             : (end_event[ch] && !(changed_q || mism)));
    assign to_viol  = in_win && !end_event[ch] && (MAX_WINDOW != 0) &&
                      (cnt_q == CW'(MAX_WINDOW));

    assign fire_d[ch]    = enable && val_viol;
    assign timeout_d[ch] = enable && to_viol;

    always_ff @(posedge clock) begin
      if (!reset) begin
        state_q   <= StIdle;
        ref_q     <= '0;
        changed_q <= 1'b0;
        cnt_q     <= '0;
        fire_q    <= 1'b0;
        timeout_q <= 1'b0;
      end else begin
        fire_q    <= fire_d[ch];
        timeout_q <= timeout_d[ch];
        unique case (state_q)
          StIdle: begin
            if (start_event[ch]) begin
              state_q   <= StWindow;
              ref_q     <= slice;
              changed_q <= 1'b0;
              cnt_q     <= CW'(1);
            end
          end
          StWindow: begin
            if (mism) changed_q <= 1'b1;
            if (cnt_q != {CW{1'b1}}) cnt_q <= cnt_q + CW'(1);
            // The end cycle wins over a timeout in the same cycle.
            if (end_event[ch] || to_viol) state_q <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end

    assign window_open[ch]  = in_win;
    assign fire[ch]         = fire_q;
    assign fire_timeout[ch] = timeout_q;
  end

  logic [CNT_W-1:0] err_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      err_q <= '0;
    end else if (|(fire_d | timeout_d) && (err_q != {CNT_W{1'b1}})) begin
      err_q <= err_q + CNT_W'(1);
    end
  end

  assign err_count = err_q;

endmodule

// File: tb/tb_ovl_win_unchange_mc.sv
// Bench for ovl_win_unchange_mc: three configurations share one stimulus stream and are
// compared each cycle against a behavioural model, plus pinned literal expectations.
module tb_ovl_win_unchange_mc;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic [1:0] start_event;
  logic [1:0] end_event;
  logic [7:0] test_expr;

  logic [1:0] wo [3];
  logic [1:0] fi [3];
  logic [1:0] ft [3];
  logic [7:0] ec [3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  ovl_win_unchange_mc #(.NCH(2), .WIDTH(4), .MODE(0), .MAX_WINDOW(0), .CNT_W(8)) d0 (
    .clock(clock), .reset(reset), .enable(enable), .start_event(start_event),
    .end_event(end_event), .test_expr(test_expr), .window_open(wo[0]), .fire(fi[0]),
    .fire_timeout(ft[0]), .err_count(ec[0]));

  ovl_win_unchange_mc #(.NCH(2), .WIDTH(4), .MODE(1), .MAX_WINDOW(0), .CNT_W(8)) d1 (
    .clock(clock), .reset(reset), .enable(enable), .start_event(start_event),
    .end_event(end_event), .test_expr(test_expr), .window_open(wo[1]), .fire(fi[1]),
    .fire_timeout(ft[1]), .err_count(ec[1]));

  ovl_win_unchange_mc #(.NCH(2), .WIDTH(4), .MODE(0), .MAX_WINDOW(4), .CNT_W(8)) d2 (
    .clock(clock), .reset(reset), .enable(enable), .start_event(start_event),
    .end_event(end_event), .test_expr(test_expr), .window_open(wo[2]), .fire(fi[2]),
    .fire_timeout(ft[2]), .err_count(ec[2]));

  // Model: per configuration and channel, whether a window is open, the value seen at
  // start, whether any different value has been seen, and how many window cycles elapsed.
  int         mode_c [3] = '{0, 1, 0};
  int         max_c  [3] = '{0, 0, 4};
  bit         m_open [3][2];
  logic [3:0] m_ref  [3][2];
  bit         m_chg  [3][2];
  int         m_age  [3][2];
  logic [1:0] e_fire [3];
  logic [1:0] e_to   [3];
  logic [1:0] e_wo   [3];
  int         e_cnt  [3];
  bit         mvalid = 1'b0;

  always @(posedge clock) begin
    for (int c = 0; c < 3; c++) begin
      bit any;
      any = 1'b0;
      for (int h = 0; h < 2; h++) begin
        bit vf;
        bit vt;
        logic [3:0] s;
        vf = 1'b0;
        vt = 1'b0;
        s  = test_expr[h*4 +: 4];
        if (!reset) begin
          m_open[c][h] = 1'b0;
          m_ref[c][h]  = '0;
          m_chg[c][h]  = 1'b0;
          m_age[c][h]  = 0;
        end else if (!m_open[c][h]) begin
          if (start_event[h]) begin
            m_open[c][h] = 1'b1;
            m_ref[c][h]  = s;
            m_chg[c][h]  = 1'b0;
            m_age[c][h]  = 1;
          end
        end else begin
          if (s != m_ref[c][h]) begin
            m_chg[c][h] = 1'b1;
            if (mode_c[c] == 0) vf = 1'b1;
          end
          if (end_event[h]) begin
            if (mode_c[c] == 1 && !m_chg[c][h]) vf = 1'b1;
            m_open[c][h] = 1'b0;
          end else if (max_c[c] > 0 && m_age[c][h] >= max_c[c]) begin
            vt = 1'b1;
            m_open[c][h] = 1'b0;
          end
          m_age[c][h] = m_age[c][h] + 1;
        end
        e_fire[c][h] = reset && enable && vf;
        e_to[c][h]   = reset && enable && vt;
        e_wo[c][h]   = m_open[c][h];
        if (e_fire[c][h] || e_to[c][h]) any = 1'b1;
      end
      if (!reset) e_cnt[c] = 0;
      else if (any && e_cnt[c] < 255) e_cnt[c] = e_cnt[c] + 1;
    end
    if (!reset) mvalid = 1'b1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (mvalid) begin
      for (int c = 0; c < 3; c++) begin
        chk($sformatf("model window_open cfg%0d", c), 32'(wo[c]), 32'(e_wo[c]));
        chk($sformatf("model fire cfg%0d", c), 32'(fi[c]), 32'(e_fire[c]));
        chk($sformatf("model fire_timeout cfg%0d", c), 32'(ft[c]), 32'(e_to[c]));
        chk($sformatf("model err_count cfg%0d", c), 32'(ec[c]), 32'(e_cnt[c]));
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b0; enable = 1'b1; start_event = '0; end_event = '0; test_expr = 8'h00;
    tick();
    chk("reset window_open", 32'(wo[0]), 32'd0);
    chk("reset err_count", 32'(ec[0]), 32'd0);
    reset = 1'b1;

    // Constant window on ch0.
    test_expr = 8'h08; start_event = 2'b01;
    tick();
    chk("t1 open", 32'(wo[0]), 32'h1);
    start_event = '0;
    repeat (4) tick();
    end_event = 2'b01;
    tick();
    end_event = '0;
    chk("t1 closed", 32'(wo[0]), 32'h0);
    chk("t1 no errors", 32'(ec[0]), 32'd0);
    chk("t1 mode1 fire ch0", 32'(fi[1]), 32'h1);

    // Mismatch from the fourth window edge through the end edge: three pulses.
    tick();
    start_event = 2'b01;
    tick();
    start_event = '0;
    repeat (2) tick();
    test_expr = 8'h09;
    tick();
    chk("t2 first pulse", 32'(fi[0]), 32'h1);
    tick();
    end_event = 2'b01;
    tick();
    end_event = '0;
    chk("t2 end pulse", 32'(fi[0]), 32'h1);
    chk("t2 count", 32'(ec[0]), 32'd3);
    tick();
    chk("t2 quiet", 32'(fi[0]), 32'h0);

    // Change mode on ch1.
    test_expr = 8'h39; start_event = 2'b10;
    tick();
    start_event = '0;
    repeat (3) tick();
    end_event = 2'b10;
    tick();
    end_event = '0;
    chk("t3 no-change fire", 32'(fi[1]), 32'h2);
    tick();
    start_event = 2'b10;
    tick();
    start_event = '0;
    tick();
    test_expr = 8'h49;
    tick();
    end_event = 2'b10;
    tick();
    end_event = '0;
    chk("t3 changed no fire", 32'(fi[1]), 32'h0);

    // Timeout on ch0.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    test_expr = 8'h05; start_event = 2'b01;
    tick();
    start_event = '0;
    repeat (3) tick();
    chk("t4 still open", 32'(wo[2]), 32'h1);
    tick();
    chk("t4 timeout", 32'(ft[2]), 32'h1);
    chk("t4 closed", 32'(wo[2]), 32'h0);
    tick();
    chk("t4 timeout single", 32'(ft[2]), 32'h0);
    start_event = 2'b01;
    tick();
    start_event = '0;
    chk("t4 reopen", 32'(wo[2]), 32'h1);
    end_event = 2'b01;
    tick();
    end_event = '0;
    chk("t4 reclosed", 32'(wo[2]), 32'h0);

    // Same-cycle start/end, no reopen, and disabled checking.
    tick();
    start_event = 2'b01; end_event = 2'b01;
    tick();
    chk("t5 start+end opens", 32'(wo[0]), 32'h1);
    start_event = '0; end_event = '0;
    tick();
    start_event = 2'b01; end_event = 2'b01;
    tick();
    start_event = '0; end_event = '0;
    chk("t5 end+start closes", 32'(wo[0]), 32'h0);
    tick();
    chk("t5 no reopen", 32'(wo[0]), 32'h0);
    enable = 1'b0; test_expr = 8'h08; start_event = 2'b01;
    tick();
    start_event = '0; test_expr = 8'h09;
    tick();
    chk("t5 disabled fire", 32'(fi[0]), 32'h0);
    chk("t5 disabled count", 32'(ec[0]), 32'd0);
    end_event = 2'b01;
    tick();
    end_event = '0; enable = 1'b1;

    // Reset mid-window with a pending mismatch.
    tick();
    test_expr = 8'h08; start_event = 2'b01;
    tick();
    start_event = '0; test_expr = 8'h09; reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("t6 reset window", 32'(wo[0]), 32'h0);
    chk("t6 reset fire", 32'(fi[0]), 32'h0);

    // Saturation of err_count.
    test_expr = 8'h88; start_event = 2'b11;
    tick();
    start_event = '0; test_expr = 8'h99;
    repeat (300) tick();
    chk("t6 saturate", 32'(ec[0]), 32'd255);
    chk("t6 both fire", 32'(fi[0]), 32'h3);
    end_event = 2'b11;
    tick();
    end_event = '0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ovl_win_unchange_mc.md
Name: ovl_win_unchange_mc

Overview:
Multi-channel, parametrised successor of the single-channel window-unchange checker in the ivl_uvm OVL checker library.
- Each of NCH channels checks one WIDTH-bit test_expr slice over a window opened by start_event and closed by end_event.
- MODE selects unchange checking or change checking.
- An optional per-channel window timeout catches windows that never close.
- Bound into test modules the same way as the existing ovl_* checkers; drives per-channel fire bits and a saturating error count.

Parameters:
- NCH, 2: number of independent channels (1..16).
- WIDTH, 4: bits of test_expr per channel.
- MODE, 0: 0 = unchange (value must stay constant inside the window); 1 = change (value must change at least once before end_event).
- MAX_WINDOW, 0: maximum window length in cycles; 0 disables the timeout.
- CNT_W, 8: width of err_count.

Ports:
- clock  input  1  checker clock, rising edge.
- reset  input  1  synchronous active-low reset.
- enable  input  1  global check enable.
- start_event  input  NCH  per-channel window open.
- end_event  input  NCH  per-channel window close.
- test_expr  input  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- window_open  output  NCH  channel i is in state WINDOW.
- fire  output  NCH  per-channel value violation, one-cycle pulse.
- fire_timeout  output  NCH  per-channel timeout, one-cycle pulse.
- err_count  output  CNT_W  saturating count of cycles with any fire or fire_timeout bit set.

Behaviour:
- Reset is synchronous and active-low; it is sampled on the rising edge of clock, with no asynchronous path.
- While reset=0 at an edge: every channel goes to IDLE, captured value = 0, changed flag = 0, window counter = 0, window_open = 0, fire = 0, fire_timeout = 0, err_count = 0.
- Reset asserted mid-window aborts the window with no fire.
- Per-channel FSM has two states, IDLE and WINDOW. All outputs are registered.
- IDLE to WINDOW:
  - Taken on an edge with start_event[i]=1.
  - test_expr slice is captured into ref[i]; changed[i] is cleared; counter[i] is set to 1.
  - end_event[i] in the same cycle is ignored.
  - window_open[i] reads 1 from the next cycle.
- WINDOW, each edge:
  - Compare the slice against ref[i].
  - MODE 0: a mismatch sets fire[i]=1 on the following cycle. Fire repeats every mismatching cycle. ref[i] is not updated.
  - MODE 1: a mismatch sets changed[i]. No fire during the window.
- WINDOW to IDLE on end_event[i]=1:
  - The end cycle's value is still compared (inclusive window).
  - MODE 1 with no change seen, including in the end cycle: fire[i]=1 on the following cycle.
  - start_event[i] in the end cycle does NOT reopen the window. A new start needs an IDLE cycle.
- start_event[i] while in WINDOW is ignored; ref[i] is not recaptured.
- Timeout (MAX_WINDOW > 0):
  - counter[i] increments each WINDOW cycle.
  - If counter[i] = MAX_WINDOW and end_event[i]=0: fire_timeout[i] pulses next cycle and the channel returns to IDLE.
  - A value check in that same cycle still applies (fire may pulse together with fire_timeout).
  - The counter saturates and never wraps.
- enable=0:
  - FSM transitions, captures and timeouts proceed normally.
  - fire and fire_timeout are forced 0 and err_count does not increment.
  - A MODE 1 end with enable=0 produces no fire.
- err_count adds 1 per cycle in which (fire | fire_timeout) != 0, regardless of how many bits are set. It holds at 2^CNT_W-1.
- Channels are fully independent; simultaneous events on different channels do not interact.
- X/Z on test_expr: treated as a mismatch in MODE 0. No separate X-check output.

Test Plan:
Common setup: 100 MHz clock, NCH=2, WIDTH=4, MODE=0, MAX_WINDOW=0 unless stated.
1. Reset low 1 cycle, enable=1, ch0 start with data=4'b1000, hold 5 cycles, end → fire=0, err_count=0, window_open[0] high for 6 cycles.
2. Same window, data changes to 4'b1001 on cycle 3 of the window and stays until end → fire[0] pulses each remaining window cycle including the end cycle; err_count equals the number of pulses; fire[1]=0.
3. MODE=1, ch1 start with 4'h3, constant until end → single fire[1] pulse the cycle after end. Repeat with one change to 4'h4 → no fire.
4. MAX_WINDOW=4, ch0 start, no end → fire_timeout[0] one pulse, window_open[0] drops after 4 window cycles; a later start reopens cleanly.
5. Start and end on ch0 in the same IDLE cycle → window opens. End plus start in a WINDOW cycle → window closes, no reopen. enable=0 during a mismatch → no fire, err_count unchanged.
6. Reset asserted mid-window with a mismatch pending → all outputs 0 the next cycle. Force >255 violations with CNT_W=8 → err_count holds at 255.
